// File: rtl/sel_debounce_pkg.sv
// Shared types and constants for the select-line debounce block.
// Holds the per-channel FSM state encoding, the legal parameter floors
// and the helper that sizes the debounce counter.
package sel_debounce_pkg;

  // Smallest synchronizer depth that still gives metastability protection
  localparam int SYNC_STAGES_MIN = 2;

  // A level must be seen for at least one cycle before it is accepted
  localparam int DEBOUNCE_MIN = 1;

  // Per-channel debounce states: settled low, qualifying a rise,
  // settled high, qualifying a fall
  typedef enum logic [1:0] {
    LO   = 2'b00,
    RISE = 2'b01,
    HI   = 2'b10,
    FALL = 2'b11
  } deb_state_e;

  // Counter width able to hold every value from 0 up to the debounce length
  function automatic int cnt_width(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/sel_debounce_if.sv
// Bundle of the raw select inputs and the conditioned select outputs.
// master: the side that drives the raw lines and consumes the results.
// slave:  the debounce block itself.
interface sel_debounce_if;

  logic raw_sel_b1;
  logic raw_sel_b2;
  logic sel_b1;
  logic sel_b2;
  logic both_sel;
  logic sel_change;

  modport master (
    output raw_sel_b1,
    output raw_sel_b2,
    input  sel_b1,
    input  sel_b2,
    input  both_sel,
    input  sel_change
  );

  modport slave (
    input  raw_sel_b1,
    input  raw_sel_b2,
    output sel_b1,
    output sel_b2,
    output both_sel,
    output sel_change
  );

endinterface

// File: rtl/sel_debounce_deb_channel.sv
// One select line: a flop-chain synchronizer followed by a debounce FSM.
// The output only moves after the synchronized level has differed from it
// for DEBOUNCE_CYCLES consecutive cycles; any bounce back restarts the count.
// 'flip' is the combinational "output changes on the coming edge" signal,
// used by the parent to register a same-edge change pulse.
module deb_channel
  import sel_debounce_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic out,
  output logic flip
);

  localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam bit SINGLE_CYCLE = (DEBOUNCE_CYCLES == 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;

  deb_state_e       state_q;
  deb_state_e       state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             out_q;
  logic             out_d;

  // Shift the raw line through the synchronizer chain, oldest bit at the top
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // Debounce state, qualification counter and registered output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LO;
      cnt_q   <= '0;
      out_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
    end
  end

  // Next-state logic: qualify a new level for DEBOUNCE_CYCLES cycles, abort on bounce
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    case (state_q)
      LO: begin
        if (s) begin
          if (SINGLE_CYCLE) begin
            state_d = HI;
            cnt_d   = '0;
            out_d   = 1'b1;
          end else begin
            state_d = RISE;
            cnt_d   = CNT_ONE;
          end
        end
      end
      RISE: begin
        if (!s) begin
          state_d = LO;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = HI;
          cnt_d   = '0;
          out_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      HI: begin
        if (!s) begin
          if (SINGLE_CYCLE) begin
            state_d = LO;
            cnt_d   = '0;
            out_d   = 1'b0;
          end else begin
            state_d = FALL;
            cnt_d   = CNT_ONE;
          end
        end
      end
      FALL: begin
        if (s) begin
          state_d = HI;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = LO;
          cnt_d   = '0;
          out_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = LO;
        cnt_d   = '0;
        out_d   = 1'b0;
      end
    endcase
  end

  assign out  = out_q;
  assign flip = out_d ^ out_q;

endmodule

// File: rtl/sel_debounce.sv
// Conditioning stage for the two mux select inputs. Each raw line gets its
// own independent synchronizer + debounce channel; this level only forms the
// combined select and the registered change pulse.
module sel_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input logic           clk,
  input logic           rst_n,
  sel_debounce_if.slave bus
);

  import sel_debounce_pkg::*;

  // Refuse to build with a synchronizer too shallow or a zero-length debounce
  generate
    if (SYNC_STAGES < SYNC_STAGES_MIN) begin : g_bad_sync
      $error("sel_debounce: SYNC_STAGES must be >= %0d", SYNC_STAGES_MIN);
    end
    if (DEBOUNCE_CYCLES < DEBOUNCE_MIN) begin : g_bad_deb
      $error("sel_debounce: DEBOUNCE_CYCLES must be >= %0d", DEBOUNCE_MIN);
    end
  endgenerate

  logic out_b1;
  logic out_b2;
  logic flip_b1;
  logic flip_b2;
  logic change_q;

  deb_channel #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_chan_b1 (
    .clk  (clk),
    .rst_n(rst_n),
    .raw  (bus.raw_sel_b1),
    .out  (out_b1),
    .flip (flip_b1)
  );

  deb_channel #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_chan_b2 (
    .clk  (clk),
    .rst_n(rst_n),
    .raw  (bus.raw_sel_b2),
    .out  (out_b2),
    .flip (flip_b2)
  );

  // Pulse high for the first cycle in which either debounced output holds a new value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      change_q <= 1'b0;
    end else begin
      change_q <= flip_b1 | flip_b2;
    end
  end

  assign bus.sel_b1     = out_b1;
  assign bus.sel_b2     = out_b2;
  assign bus.both_sel   = out_b1 & out_b2;
  assign bus.sel_change = change_q;

endmodule

// File: tb/tb_sel_debounce.sv
// Bench for sel_debounce: two instances (default parameters, and
// SYNC_STAGES=3 / DEBOUNCE_CYCLES=1) driven with directed and random raw
// select patterns. Expected outputs come from a window model: the output of a
// line flips at edge t when the raw values sampled at edges t-S .. t-S-D+1
// all differ from the current output.
module tb_sel_debounce;

  localparam int SA = 2;
  localparam int DA = 4;
  localparam int SB = 3;
  localparam int DB = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  sel_debounce_if ifa ();
  sel_debounce_if ifb ();

  sel_debounce #(
    .SYNC_STAGES    (SA),
    .DEBOUNCE_CYCLES(DA)
  ) dut_a (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (ifa)
  );

  sel_debounce #(
    .SYNC_STAGES    (SB),
    .DEBOUNCE_CYCLES(DB)
  ) dut_b (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (ifb)
  );

  int cmp_count = 0;
  int err_count = 0;
  string phase = "init";

  logic [63:0] hist [2][2];
  logic        mout [2][2];
  logic        mchg [2];

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    cmp_count++;
    if (observed !== expected) begin
      err_count++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < 2; c++) begin
        hist[d][c] = '0;
        mout[d][c] = 1'b0;
      end
      mchg[d] = 1'b0;
    end
  endtask

  task automatic modelEdge(input int d, input int s, input int dl,
                           input logic r1, input logic r2);
    logic r [2];
    logic fl [2];
    r[0] = r1;
    r[1] = r2;
    for (int c = 0; c < 2; c++) begin
      hist[d][c] = {hist[d][c][62:0], r[c]};
      fl[c] = 1'b1;
      for (int k = 0; k < dl; k++) begin
        if (hist[d][c][s + k] == mout[d][c]) fl[c] = 1'b0;
      end
      if (fl[c]) mout[d][c] = ~mout[d][c];
    end
    mchg[d] = fl[0] | fl[1];
  endtask

  task automatic checkAll();
    checkOutput({phase, ".a.sel_b1"},     ifa.sel_b1,     mout[0][0]);
    checkOutput({phase, ".a.sel_b2"},     ifa.sel_b2,     mout[0][1]);
    checkOutput({phase, ".a.both_sel"},   ifa.both_sel,   mout[0][0] & mout[0][1]);
    checkOutput({phase, ".a.sel_change"}, ifa.sel_change, mchg[0]);
    checkOutput({phase, ".b.sel_b1"},     ifb.sel_b1,     mout[1][0]);
    checkOutput({phase, ".b.sel_b2"},     ifb.sel_b2,     mout[1][1]);
    checkOutput({phase, ".b.both_sel"},   ifb.both_sel,   mout[1][0] & mout[1][1]);
    checkOutput({phase, ".b.sel_change"}, ifb.sel_change, mchg[1]);
  endtask

  // Called just after a falling edge: drive raws, take one rising edge, check at the next fall
  task automatic applyStimulus(input logic a1, input logic a2, input logic b1, input logic b2);
    ifa.raw_sel_b1 = a1;
    ifa.raw_sel_b2 = a2;
    ifb.raw_sel_b1 = b1;
    ifb.raw_sel_b2 = b2;
    @(posedge clk);
    if (rst_n) begin
      modelEdge(0, SA, DA, a1, a2);
      modelEdge(1, SB, DB, b1, b2);
    end
    @(negedge clk);
    checkAll();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  int lat_a, lat_b, lat_a2, chg_a, bad_a;
  logic ra1, ra2, rb1, rb2;

  initial begin
    modelReset();
    ifa.raw_sel_b1 = 1'b1;
    ifa.raw_sel_b2 = 1'b1;
    ifb.raw_sel_b1 = 1'b1;
    ifb.raw_sel_b2 = 1'b1;
    @(negedge clk);

    // Reset held with raw lines high: everything stays low
    phase = "reset_hold";
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
    ifa.raw_sel_b1 = 1'b0;
    ifa.raw_sel_b2 = 1'b0;
    ifb.raw_sel_b1 = 1'b0;
    ifb.raw_sel_b2 = 1'b0;
    rst_n = 1'b1;
    phase = "idle";
    idle(4);

    // Clean rise on select 1: edge 6 for defaults, edge 4 for S=3/D=1
    phase = "clean_rise";
    lat_a = -1;
    lat_b = -1;
    chg_a = 0;
    for (int i = 1; i <= 10; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
      if (ifa.sel_b1 === 1'b1 && lat_a < 0) lat_a = i;
      if (ifb.sel_b1 === 1'b1 && lat_b < 0) lat_b = i;
      if (ifa.sel_change === 1'b1) chg_a++;
    end
    checkOutput("latency_a", lat_a, 6);
    checkOutput("latency_b", lat_b, 4);
    checkOutput("rise_pulses_a", chg_a, 1);
    idle(10);

    // Three-cycle glitch on select 2 is rejected, a four-cycle pulse is accepted
    phase = "glitch";
    bad_a = 0;
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      if (ifa.sel_b2 !== 1'b0 || ifa.sel_change !== 1'b0) bad_a++;
    end
    checkOutput("glitch_reject_a", bad_a, 0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("pulse4_accept_a", ifa.sel_b2, 1);
    idle(10);

    // Both lines move together: same-edge rise/fall, one pulse each way
    phase = "simultaneous";
    for (int pass = 0; pass < 2; pass++) begin
      logic lvl;
      int e1, e2;
      lvl = (pass == 0);
      e1 = -1;
      e2 = -1;
      chg_a = 0;
      for (int i = 1; i <= 10; i++) begin
        applyStimulus(lvl, lvl, lvl, lvl);
        if (ifa.sel_b1 === lvl && e1 < 0) e1 = i;
        if (ifa.sel_b2 === lvl && e2 < 0) e2 = i;
        if (ifa.sel_change === 1'b1) chg_a++;
      end
      checkOutput(pass == 0 ? "simul_rise_b1" : "simul_fall_b1", e1, 6);
      checkOutput(pass == 0 ? "simul_rise_b2" : "simul_fall_b2", e2, 6);
      checkOutput(pass == 0 ? "simul_rise_pulses" : "simul_fall_pulses", chg_a, 1);
    end
    idle(4);

    // Reset in the middle of a rise count while select 2 is already high
    phase = "reset_mid";
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
    checkOutput("premid_a_sel_b2", ifa.sel_b2, 1);
    #1;
    rst_n = 1'b0;
    modelReset();
    #1;
    checkAll();
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
    rst_n = 1'b1;
    phase = "requalify";
    lat_a2 = -1;
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
      if (ifa.sel_b1 === 1'b1 && lat_a2 < 0) lat_a2 = i;
    end
    checkOutput("latency_after_reset_a", lat_a2, 6);
    idle(10);

    // Random bursty toggling on all four raw lines, with one async reset
    phase = "random";
    ra1 = 1'b0;
    ra2 = 1'b0;
    rb1 = 1'b0;
    rb2 = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) ra1 = ~ra1;
      if ($urandom_range(0, 4) == 0) ra2 = ~ra2;
      if ($urandom_range(0, 2) == 0) rb1 = ~rb1;
      if ($urandom_range(0, 5) == 0) rb2 = ~rb2;
      applyStimulus(ra1, ra2, rb1, rb2);
      if (i == 300) begin
        #2;
        rst_n = 1'b0;
        modelReset();
        #1;
        checkAll();
        applyStimulus(ra1, ra2, rb1, rb2);
        applyStimulus(ra1, ra2, rb1, rb2);
        rst_n = 1'b1;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
    $finish;
  end

endmodule
